// File: rtl/ps2_kb_pkg.sv
// Shared scan-code constants, decoder state encoding, key-event layout and
// the set-2 scan-code to ASCII translation used by the key decoder.
package ps2_kb_pkg;

  localparam logic [7:0] BRK_PFX = 8'hF0;
  localparam logic [7:0] EXT_PFX = 8'hE0;
  localparam logic [7:0] LSHIFT  = 8'h12;
  localparam logic [7:0] RSHIFT  = 8'h59;
  localparam logic [7:0] CTRL    = 8'h14;
  localparam logic [7:0] CAPS    = 8'h58;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  localparam int SCAN_W  = 8;
  localparam int ASCII_W = 8;
  localparam int MODS_W  = 3;

  typedef struct packed {
    logic [SCAN_W-1:0]  scan;
    logic [ASCII_W-1:0] ascii;
    logic               ext;
    logic [MODS_W-1:0]  mods;
  } evt_t;

  localparam int EVT_W = $bits(evt_t);

  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic shift,
                                               input logic caps, input logic ctrl);
    logic [7:0] letter;
    logic [7:0] dig;
    logic [7:0] sym;
    logic [7:0] res;
    letter = 8'h00;
    dig    = 8'h00;
    sym    = 8'h00;
    res    = 8'h00;
    // Letters resolve to their uppercase ASCII; case is chosen afterwards.
    case (code)
      8'h1C: letter = 8'h41;  8'h32: letter = 8'h42;  8'h21: letter = 8'h43;
      8'h23: letter = 8'h44;  8'h24: letter = 8'h45;  8'h2B: letter = 8'h46;
      8'h34: letter = 8'h47;  8'h33: letter = 8'h48;  8'h43: letter = 8'h49;
      8'h3B: letter = 8'h4A;  8'h42: letter = 8'h4B;  8'h4B: letter = 8'h4C;
      8'h3A: letter = 8'h4D;  8'h31: letter = 8'h4E;  8'h44: letter = 8'h4F;
      8'h4D: letter = 8'h50;  8'h15: letter = 8'h51;  8'h2D: letter = 8'h52;
      8'h1B: letter = 8'h53;  8'h2C: letter = 8'h54;  8'h3C: letter = 8'h55;
      8'h2A: letter = 8'h56;  8'h1D: letter = 8'h57;  8'h22: letter = 8'h58;
      8'h35: letter = 8'h59;  8'h1A: letter = 8'h5A;
      default: letter = 8'h00;
    endcase
    case (code)
      8'h45: begin dig = 8'h30; sym = 8'h29; end
      8'h16: begin dig = 8'h31; sym = 8'h21; end
      8'h1E: begin dig = 8'h32; sym = 8'h40; end
      8'h26: begin dig = 8'h33; sym = 8'h23; end
      8'h25: begin dig = 8'h34; sym = 8'h24; end
      8'h2E: begin dig = 8'h35; sym = 8'h25; end
      8'h36: begin dig = 8'h36; sym = 8'h5E; end
      8'h3D: begin dig = 8'h37; sym = 8'h26; end
      8'h3E: begin dig = 8'h38; sym = 8'h2A; end
      8'h46: begin dig = 8'h39; sym = 8'h28; end
      default: begin dig = 8'h00; sym = 8'h00; end
    endcase
    if (letter != 8'h00) begin
      if (ctrl)              res = letter & 8'h1F;
      else if (shift ^ caps) res = letter;
      else                   res = letter + 8'h20;
    end else if (dig != 8'h00) begin
      res = shift ? sym : dig;
    end else begin
      case (code)
        8'h29:   res = 8'h20;
        8'h5A:   res = 8'h0D;
        8'h66:   res = 8'h08;
        default: res = 8'h00;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Generic synchronous FIFO; pointers carry one extra wrap bit so full and
// empty are told apart by the MSB. A push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module ps2_evt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key decoder: prefix tracking, modifier state, ASCII translation,
// a press counter and a valid/ready event queue for the CPU side.
import ps2_kb_pkg::*;

module ps2_key_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8,
  parameter int EXT_EN     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_scan,
  output logic [7:0]       out_ascii,
  output logic             out_ext,
  output logic [2:0]       out_mods,
  output logic             shift_flag,
  output logic             ctrl_flag,
  output logic             caps_flag,
  output logic [CNT_W-1:0] press_cnt,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  // Handshake: the head event is offered while out_valid is high and is
  // consumed on a cycle where out_valid && out_ready; fields stay put until then.

  state_t           state_q;
  logic             shift_q, ctrl_q, caps_q, ovf_q;
  logic [7:0]       held_q;
  logic [CNT_W-1:0] cnt_q;
  evt_t             last_q;
  evt_t             push_evt, head, shown;
  logic             push, pop, full, empty, is_mod;
  logic [2:0]       mods;

  assign mods   = {caps_q, ctrl_q, shift_q};
  assign is_mod = (rx_data == LSHIFT) || (rx_data == RSHIFT) ||
                  (rx_data == CTRL) || (rx_data == CAPS);
  assign pop    = !empty && out_ready;

  always_comb begin
    push     = 1'b0;
    push_evt = '{scan: rx_data, ascii: 8'h00, ext: 1'b0, mods: mods};
    if (rx_valid) begin
      case (state_q)
        IDLE: begin
          if (rx_data != EXT_PFX && rx_data != BRK_PFX && !is_mod) begin
            push           = 1'b1;
            push_evt.ascii = scan_to_ascii(rx_data, shift_q, caps_q, ctrl_q);
          end
        end
        EXT: begin
          if (rx_data != BRK_PFX && rx_data != CTRL && EXT_EN != 0) begin
            push         = 1'b1;
            push_evt.ext = 1'b1;
          end
        end
        default: push = 1'b0;
      endcase
    end
  end

  ps2_evt_fifo #(.WIDTH(EVT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_evt),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= 1'b0;
      ctrl_q  <= 1'b0;
      caps_q  <= 1'b0;
      ovf_q   <= 1'b0;
      held_q  <= 8'h00;
      cnt_q   <= '0;
      last_q  <= '0;
    end else begin
      if (push && full && !pop) ovf_q <= 1'b1;
      if (!empty) last_q <= head;
      if (rx_valid) begin
        case (state_q)
          IDLE: begin
            if (rx_data == EXT_PFX) begin
              state_q <= EXT;
            end else if (rx_data == BRK_PFX) begin
              state_q <= BRK;
            end else begin
              if (rx_data == LSHIFT || rx_data == RSHIFT) shift_q <= 1'b1;
              else if (rx_data == CTRL) ctrl_q <= 1'b1;
              else if (rx_data == CAPS) begin
                // Typematic repeats of CapsLock must not flip the lock again.
                if (held_q != CAPS) caps_q <= ~caps_q;
              end else if (rx_data != held_q) cnt_q <= cnt_q + CNT_W'(1);
              held_q <= rx_data;
            end
          end
          EXT: begin
            if (rx_data == BRK_PFX) begin
              state_q <= EXT_BRK;
            end else begin
              if (rx_data == CTRL) ctrl_q <= 1'b1;
              state_q <= IDLE;
            end
          end
          BRK: begin
            if (rx_data == LSHIFT || rx_data == RSHIFT) shift_q <= 1'b0;
            if (rx_data == CTRL) ctrl_q <= 1'b0;
            if (rx_data == held_q) held_q <= 8'h00;
            state_q <= IDLE;
          end
          EXT_BRK: begin
            if (rx_data == CTRL) ctrl_q <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign shown      = empty ? last_q : head;
  assign out_valid  = !empty;
  assign out_scan   = shown.scan;
  assign out_ascii  = shown.ascii;
  assign out_ext    = shown.ext;
  assign out_mods   = shown.mods;
  assign shift_flag = shift_q;
  assign ctrl_flag  = ctrl_q;
  assign caps_flag  = caps_q;
  assign press_cnt  = cnt_q;
  assign overflow   = ovf_q;
  assign dbg_state  = state_q;

endmodule
